// File: rtl/mem_stall_unit.sv
// Memory stall unit: issues IF/MEM memory requests, holds them until answered,
// captures early responses and stalls the whole pipeline until every access this cycle is done.
module mem_stall_unit #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [XLEN-1:0]  if_addr,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  input  logic [3:0]       mem_mbe,
  input  logic             imem_resp,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             dmem_resp,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             imem_read,
  output logic [XLEN-1:0]  imem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [XLEN-1:0]  dmem_address,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_mbe,
  output logic             stall_pipeline,
  output logic [XLEN-1:0]  if_rdata,
  output logic [XLEN-1:0]  mem_rdata,
  output logic [CNT_W-1:0] stall_count,
  output logic             timeout_err
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

  typedef enum logic {PEND = 1'b0, DONE = 1'b1} port_state_t;

  port_state_t i_state, i_state_nxt, d_state, d_state_nxt;
  logic i_done, d_done, i_ok, d_ok, d_active;
  logic [XLEN-1:0]   if_rdata_q, mem_rdata_q;
  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state <= PEND;
      d_state <= PEND;
    end else begin
      i_state <= i_state_nxt;
      d_state <= d_state_nxt;
    end
  end

  // A response only counts as "early" when the pipeline is held; otherwise it is consumed this cycle.
  always_comb begin
    i_state_nxt = i_state;
    d_state_nxt = d_state;
    case (i_state)
      PEND:    if (if_req && imem_resp && stall_pipeline) i_state_nxt = DONE;
      DONE:    if (!stall_pipeline) i_state_nxt = PEND;
      default: i_state_nxt = PEND;
    endcase
    case (d_state)
      PEND:    if (d_active && dmem_resp && stall_pipeline) d_state_nxt = DONE;
      DONE:    if (!stall_pipeline) d_state_nxt = PEND;
      default: d_state_nxt = PEND;
    endcase
  end

  always_comb begin
    i_done         = (i_state == DONE);
    d_done         = (d_state == DONE);
    d_active       = mem_read | mem_write;
    imem_read      = if_req & ~i_done;
    dmem_read      = mem_read & ~d_done;
    dmem_write     = mem_write & ~d_done;
    imem_address   = if_addr;
    dmem_address   = mem_addr;
    dmem_wdata     = mem_wdata;
    dmem_mbe       = mem_mbe;
    i_ok           = ~if_req | i_done | imem_resp;
    d_ok           = ~d_active | d_done | dmem_resp;
    stall_pipeline = ~(i_ok & d_ok);
    if_rdata       = imem_resp ? imem_rdata : if_rdata_q;
    mem_rdata      = dmem_resp ? dmem_rdata : mem_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (i_state == PEND && i_state_nxt == DONE) if_rdata_q  <= imem_rdata;
      if (d_state == PEND && d_state_nxt == DONE) mem_rdata_q <= dmem_rdata;
    end
  end

  // wait_cnt saturates at TIMEOUT so a long stall cannot wrap it back below the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (stall_pipeline) begin
      stall_count <= stall_count + 1'b1;
      if (wait_cnt != TO_VAL) wait_cnt <= wait_cnt + 1'b1;
      if (TIMEOUT != 0 && wait_cnt == TO_VAL - 1'b1) timeout_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stall_unit.sv
// Directed bench for mem_stall_unit: inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_mem_stall_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_read, mem_write, imem_resp, dmem_resp;
  logic [31:0] if_addr, mem_addr, mem_wdata, imem_rdata, dmem_rdata;
  logic [3:0]  mem_mbe;
  logic        imem_read, dmem_read, dmem_write, stall_pipeline, timeout_err;
  logic [31:0] imem_address, dmem_address, dmem_wdata, if_rdata, mem_rdata, stall_count;
  logic [3:0]  dmem_mbe;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stall_unit #(.XLEN(32), .CNT_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe), .imem_resp(imem_resp),
    .imem_rdata(imem_rdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .imem_read(imem_read), .imem_address(imem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_mbe(dmem_mbe), .stall_pipeline(stall_pipeline), .if_rdata(if_rdata),
    .mem_rdata(mem_rdata), .stall_count(stall_count), .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; mem_read = 0; mem_write = 0; imem_resp = 0; dmem_resp = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_mbe = 0; imem_rdata = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #3;
    tests++; if (stall_pipeline !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall_pipeline); end
    tests++; if ({imem_read, dmem_read, dmem_write} !== 3'b000) begin fails++; $display("FAIL reset_req: got %b expected 000", {imem_read, dmem_read, dmem_write}); end
    tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
    tests++; if ({if_rdata, mem_rdata} !== 64'd0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, mem_rdata}); end
    step();
    rst = 0;
  endtask

  task automatic test_zero_latency();
    if_req = 1; if_addr = 32'h0; imem_resp = 1; imem_rdata = 32'h00000013;
    @(negedge clk);
    tests++; if (stall_pipeline !== 1'b0) begin fails++; $display("FAIL zl_stall: got %b expected 0", stall_pipeline); end
    tests++; if (if_rdata !== 32'h00000013) begin fails++; $display("FAIL zl_rdata: got %h expected 00000013", if_rdata); end
    tests++; if (imem_read !== 1'b1) begin fails++; $display("FAIL zl_read: got %b expected 1", imem_read); end
    step(); idle();
    @(negedge clk);
    tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL zl_count: got %0d expected 0", stall_count); end
    step();
  endtask

  task automatic test_fetch_load();
    if_req = 1; if_addr = 32'h40; mem_read = 1; mem_addr = 32'h100;
    for (int c = 0; c <= 5; c++) begin
      imem_resp  = (c == 2) || (c == 4);
      imem_rdata = (c == 2) ? 32'h12345678 : (c == 4) ? 32'hBAD0BAD0 : 32'hFFFFFFFF;
      dmem_resp  = (c == 5);
      dmem_rdata = (c == 5) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      tests++; if (stall_pipeline !== (c < 5)) begin fails++; $display("FAIL fl_stall c%0d: got %b expected %b", c, stall_pipeline, c < 5); end
      tests++; if (imem_read !== (c < 3)) begin fails++; $display("FAIL fl_iread c%0d: got %b expected %b", c, imem_read, c < 3); end
      tests++; if (dmem_read !== 1'b1 || dmem_address !== 32'h100) begin fails++; $display("FAIL fl_dreq c%0d: got %b/%h expected 1/00000100", c, dmem_read, dmem_address); end
      if (c >= 2 && c != 4) begin
        tests++; if (if_rdata !== 32'h12345678) begin fails++; $display("FAIL fl_if_rdata c%0d: got %h expected 12345678", c, if_rdata); end
      end
      if (c == 5) begin
        tests++; if (mem_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL fl_mem_rdata: got %h expected deadbeef", mem_rdata); end
        tests++; if (stall_count !== 32'd5) begin fails++; $display("FAIL fl_count: got %0d expected 5", stall_count); end
      end
      step();
    end
    // next fetch must be issued again: done flags cleared after the release cycle
    mem_read = 0; dmem_resp = 0; imem_resp = 1; imem_rdata = 32'h00000093;
    @(negedge clk);
    tests++; if (imem_read !== 1'b1 || stall_pipeline !== 1'b0) begin fails++; $display("FAIL fl_reissue: got %b/%b expected 1/0", imem_read, stall_pipeline); end
    step(); idle();
  endtask

  task automatic test_store();
    mem_write = 1; mem_addr = 32'h200; mem_wdata = 32'hCAFEF00D; mem_mbe = 4'b0011;
    for (int c = 0; c <= 3; c++) begin
      dmem_resp = (c == 3);
      @(negedge clk);
      tests++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0) begin fails++; $display("FAIL st_write c%0d: got %b%b expected 10", c, dmem_write, dmem_read); end
      tests++; if ({dmem_address, dmem_wdata, dmem_mbe} !== {32'h200, 32'hCAFEF00D, 4'b0011}) begin fails++; $display("FAIL st_bus c%0d: got %h %h %b expected 00000200 cafef00d 0011", c, dmem_address, dmem_wdata, dmem_mbe); end
      tests++; if (stall_pipeline !== (c < 3)) begin fails++; $display("FAIL st_stall c%0d: got %b expected %b", c, stall_pipeline, c < 3); end
      step();
    end
    idle();
    @(negedge clk);
    tests++; if (dmem_write !== 1'b0 || stall_count !== 32'd8) begin fails++; $display("FAIL st_after: got %b/%0d expected 0/8", dmem_write, stall_count); end
    step();
  endtask

  task automatic test_both_same_cycle();
    if_req = 1; mem_read = 1; if_addr = 32'h44; mem_addr = 32'h104;
    for (int c = 0; c <= 5; c++) begin
      imem_resp = (c == 4); dmem_resp = (c == 4);
      imem_rdata = 32'hA0A0A0A0; dmem_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      if (c <= 4) begin
        tests++; if (stall_pipeline !== (c < 4)) begin fails++; $display("FAIL both_stall c%0d: got %b expected %b", c, stall_pipeline, c < 4); end
      end else begin
        tests++; if ({imem_read, dmem_read, stall_pipeline} !== 3'b111) begin fails++; $display("FAIL both_done_cleared: got %b expected 111", {imem_read, dmem_read, stall_pipeline}); end
      end
      step();
    end
    idle();
    @(negedge clk);
    tests++; if (stall_count !== 32'd13) begin fails++; $display("FAIL both_count: got %0d expected 13", stall_count); end
    step();
  endtask

  task automatic test_illegal_rw();
    mem_read = 1; mem_write = 1; mem_addr = 32'h300; dmem_resp = 1;
    $display("[TB] note: driving mem_read and mem_write together (illegal input)");
    @(negedge clk);
    tests++; if ({dmem_read, dmem_write, stall_pipeline} !== 3'b110) begin fails++; $display("FAIL illegal_fwd: got %b expected 110", {dmem_read, dmem_write, stall_pipeline}); end
    step(); idle();
  endtask

  task automatic test_timeout();
    if_req = 1; if_addr = 32'h80;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      tests++; if (timeout_err !== (c >= 8) || stall_pipeline !== 1'b1) begin fails++; $display("FAIL to_c%0d: got err=%b stall=%b expected err=%b stall=1", c, timeout_err, stall_pipeline, c >= 8); end
      step();
    end
  endtask

  task automatic test_async_reset();
    mem_read = 1; mem_addr = 32'h180; imem_resp = 1; imem_rdata = 32'h0BADF00D;
    step();
    imem_resp = 0; imem_rdata = 32'h0;
    @(negedge clk);
    tests++; if (imem_read !== 1'b0 || if_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL ar_done: got %b/%h expected 0/0badf00d", imem_read, if_rdata); end
    #2; rst = 1; #1;
    tests++; if (stall_count !== 32'd0 || timeout_err !== 1'b0) begin fails++; $display("FAIL ar_clear: got %0d/%b expected 0/0", stall_count, timeout_err); end
    tests++; if (if_rdata !== 32'h0 || imem_read !== 1'b1 || dmem_read !== 1'b1) begin fails++; $display("FAIL ar_flags: got %h/%b/%b expected 0/1/1", if_rdata, imem_read, dmem_read); end
    step(); rst = 0;
    @(negedge clk);
    tests++; if (imem_read !== 1'b1 || stall_pipeline !== 1'b1 || stall_count !== 32'd0) begin fails++; $display("FAIL ar_reissue: got %b/%b/%0d expected 1/1/0", imem_read, stall_pipeline, stall_count); end
    step();
    imem_resp = 1; dmem_resp = 1; imem_rdata = 32'h13; dmem_rdata = 32'h77;
    @(negedge clk);
    tests++; if (stall_pipeline !== 1'b0 || stall_count !== 32'd1 || mem_rdata !== 32'h77) begin fails++; $display("FAIL ar_release: got %b/%0d/%h expected 0/1/00000077", stall_pipeline, stall_count, mem_rdata); end
    step(); idle();
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_fetch_load();
    test_store();
    test_both_same_cycle();
    test_illegal_rw();
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL pre_timeout: got %b expected 0", timeout_err); end
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
